mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mips_defs.sv | 34 +++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_defs.sv
// Shared definitions for the memory arbiter: data/address width, FSM state codes, request record.
// Latency: none (package, no logic).
// Backpressure: n/a; the round-robin pick helper is used only when MEM_ARBITER_RR_EN is defined.
package mips_defs;

    // Width of every data and address bus in the memory path
    localparam int XLEN = 32;

    // Arbiter FSM state encoding (2-bit)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_IBUSY = 2'd1;
    localparam logic [1:0] ST_DBUSY = 2'd2;

    // Request captured at grant time; the memory port is driven only from this record
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic            we;
        logic [XLEN-1:0] wdata;
    } mem_cmd_t;

    // Round-robin pick: 1 selects the data side. With both sides requesting,
    // the side that did not win last time gets the grant.
    function automatic logic rr_pick_data(input logic ireq, input logic dreq,
                                          input logic last_was_data);
        logic pick;
        if (ireq && dreq) begin
            pick = !last_was_data;
        end else begin
            pick = dreq;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one memory port; IDLE/IBUSY/DBUSY FSM, fixed data-first priority or round-robin under MEM_ARBITER_RR_EN.
// Latency: request in cycle N -> mreq in N+1 -> earliest ack in N+1; one idle bubble after every ack.
// Backpressure: mreq held until mready; requesters hold req/operands until their one-cycle ack; requests are ignored while busy.
module mem_arbiter
    import mips_defs::*;
(
    input  logic            clk,
    input  logic            rst,
    // fetch port
    input  logic            ireq,
    input  logic [XLEN-1:0] iaddr,
    output logic [XLEN-1:0] irdata,
    output logic            iack,
    // data port
    input  logic            dreq,
    input  logic            dwe,
    input  logic [XLEN-1:0] daddr,
    input  logic [XLEN-1:0] dwdata,
    output logic [XLEN-1:0] drdata,
    output logic            dack,
    // memory port
    output logic            mreq,
    output logic            mwe,
    output logic [XLEN-1:0] maddr,
    output logic [XLEN-1:0] mwdata,
    input  logic [XLEN-1:0] mrdata,
    input  logic            mready
);

    logic [1:0]  state;
    mem_cmd_t    cmd;
    logic        grant_d;
    logic        grant_i;
    logic        in_idle;
    logic        done;

    assign in_idle = (state == ST_IDLE);

    // A busy state finishes when memory reports completion; reset wins over mready
    assign done = !in_idle && mready && !rst;

`ifdef MEM_ARBITER_RR_EN
    // Set when the most recent grant went to the data side
    logic last_d;

    // Round-robin grant decision, only meaningful while idle
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (in_idle) begin
            grant_d = rr_pick_data(ireq, dreq, last_d);
            grant_i = ireq && !grant_d;
        end
    end

    // Remember who won so a simultaneous request next time goes to the other side
    always_ff @(posedge clk) begin
        if (rst) begin
            last_d <= 1'b1;
        end else if (grant_d) begin
            last_d <= 1'b1;
        end else if (grant_i) begin
            last_d <= 1'b0;
        end
    end
`else
    // Fixed-priority grant decision: data beats fetch
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (in_idle) begin
            grant_d = dreq;
            grant_i = ireq && !dreq;
        end
    end
`endif

    // FSM: idle -> busy on grant, busy -> idle on completion, reset abandons any access
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_d) begin
                        state <= ST_DBUSY;
                    end else if (grant_i) begin
                        state <= ST_IBUSY;
                    end
                end
                ST_IBUSY,
                ST_DBUSY: begin
                    if (mready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Capture the winning request so later operand changes cannot disturb the access
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd <= '0;
        end else if (grant_d) begin
            cmd.addr  <= daddr;
            cmd.we    <= dwe;
            cmd.wdata <= dwdata;
        end else if (grant_i) begin
            cmd.addr  <= iaddr;
            cmd.we    <= 1'b0;
            cmd.wdata <= '0;
        end
    end

    // Load read data on the ack edge; a data write leaves drdata untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            irdata <= '0;
            drdata <= '0;
        end else if (done) begin
            if (state == ST_IBUSY) begin
                irdata <= mrdata;
            end else if (state == ST_DBUSY && !cmd.we) begin
                drdata <= mrdata;
            end
        end
    end

    assign mreq   = !in_idle;
    assign maddr  = cmd.addr;
    assign mwe    = cmd.we;
    assign mwdata = cmd.wdata;

    assign iack = done && (state == ST_IBUSY);
    assign dack = done && (state == ST_DBUSY);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, collision, operand hold, stray mready, reset mid-access, arbitration order.
// Latency: inputs change 1ns after posedge, outputs sampled on negedge.
// Backpressure: mready driven directly by the bench per vector.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic [31:0] irdata;
    logic        iack;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] drdata;
    logic        dack;
    logic        mreq;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] mrdata;
    logic        mready;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter dut (
        .clk    (clk),
        .rst    (rst),
        .ireq   (ireq),
        .iaddr  (iaddr),
        .irdata (irdata),
        .iack   (iack),
        .dreq   (dreq),
        .dwe    (dwe),
        .daddr  (daddr),
        .dwdata (dwdata),
        .drdata (drdata),
        .dack   (dack),
        .mreq   (mreq),
        .mwe    (mwe),
        .maddr  (maddr),
        .mwdata (mwdata),
        .mrdata (mrdata),
        .mready (mready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait until the sampling point of the current cycle
    task automatic sample();
        @(negedge clk);
    endtask

    // Expected grant sequence (1 = data) with both requests held high from reset
    logic exp_d [4];
    logic [31:0] exp_a;

    initial begin
`ifdef MEM_ARBITER_RR_EN
        exp_d[0] = 1'b0; exp_d[1] = 1'b1; exp_d[2] = 1'b0; exp_d[3] = 1'b1;
`else
        exp_d[0] = 1'b1; exp_d[1] = 1'b1; exp_d[2] = 1'b1; exp_d[3] = 1'b1;
`endif
        rst = 1'b1; ireq = 1'b0; iaddr = '0; dreq = 1'b0; dwe = 1'b0;
        daddr = '0; dwdata = '0; mrdata = '0; mready = 1'b0;
        tick();
        tick();
        sample();
        check("rst_mreq",   {31'd0, mreq}, 32'd0);
        check("rst_acks",   {30'd0, iack, dack}, 32'd0);
        check("rst_maddr",  maddr, 32'd0);
        check("rst_mwe",    {31'd0, mwe}, 32'd0);
        check("rst_mwdata", mwdata, 32'd0);
        check("rst_irdata", irdata, 32'd0);
        check("rst_drdata", drdata, 32'd0);
        tick();
        rst = 1'b0;

        // ---- fetch only, mready in the second busy cycle ----
        ireq = 1'b1; iaddr = 32'h0000_0040;
        sample();
        check("f_idle_mreq", {31'd0, mreq}, 32'd0);
        tick();
        sample();
        check("f_b1_mreq",  {31'd0, mreq}, 32'd1);
        check("f_b1_maddr", maddr, 32'h40);
        check("f_b1_mwe",   {31'd0, mwe}, 32'd0);
        check("f_b1_iack",  {31'd0, iack}, 32'd0);
        tick();
        mready = 1'b1; mrdata = 32'h2008_0005;
        sample();
        check("f_b2_mreq", {31'd0, mreq}, 32'd1);
        check("f_b2_iack", {31'd0, iack}, 32'd1);
        check("f_b2_dack", {31'd0, dack}, 32'd0);
        tick();
        ireq = 1'b0; mready = 1'b0;
        sample();
        check("f_done_iack",   {31'd0, iack}, 32'd0);
        check("f_done_mreq",   {31'd0, mreq}, 32'd0);
        check("f_done_irdata", irdata, 32'h2008_0005);

        // ---- collision: both request in the same cycle ----
        ireq = 1'b1; iaddr = 32'h0000_0080;
        dreq = 1'b1; daddr = 32'h0000_0100; dwe = 1'b1; dwdata = 32'hDEAD_BEEF;
        tick();
        mready = 1'b1; mrdata = 32'h7777_7777;
        sample();
        check("c_d_mreq",   {31'd0, mreq}, 32'd1);
        check("c_d_mwe",    {31'd0, mwe}, 32'd1);
        check("c_d_maddr",  maddr, 32'h100);
        check("c_d_mwdata", mwdata, 32'hDEAD_BEEF);
        check("c_d_dack",   {31'd0, dack}, 32'd1);
        check("c_d_iack",   {31'd0, iack}, 32'd0);
        tick();
        dreq = 1'b0; dwe = 1'b0; mready = 1'b0;
        sample();
        check("c_bubble_mreq", {31'd0, mreq}, 32'd0);
        check("c_bubble_acks", {30'd0, iack, dack}, 32'd0);
        check("c_write_drdata", drdata, 32'd0);
        tick();
        mready = 1'b1; mrdata = 32'h1111_2222;
        sample();
        check("c_i_maddr", maddr, 32'h80);
        check("c_i_mwe",   {31'd0, mwe}, 32'd0);
        check("c_i_iack",  {31'd0, iack}, 32'd1);
        tick();
        ireq = 1'b0; mready = 1'b0;
        sample();
        check("c_i_irdata", irdata, 32'h1111_2222);
        check("c_end_mreq", {31'd0, mreq}, 32'd0);

        // ---- operands change after grant ----
        dreq = 1'b1; dwe = 1'b0; daddr = 32'h0000_0100;
        tick();
        daddr = 32'h0000_0200; dwe = 1'b1; dwdata = 32'h1234_5678;
        sample();
        check("o_b1_maddr", maddr, 32'h100);
        check("o_b1_mwe",   {31'd0, mwe}, 32'd0);
        tick();
        mready = 1'b1; mrdata = 32'h0BAD_F00D;
        sample();
        check("o_b2_maddr", maddr, 32'h100);
        check("o_b2_dack",  {31'd0, dack}, 32'd1);
        tick();
        dreq = 1'b0; dwe = 1'b0; mready = 1'b0;
        sample();
        check("o_drdata", drdata, 32'h0BAD_F00D);

        // ---- stray mready while idle ----
        mready = 1'b1; mrdata = 32'h5555_5555;
        sample();
        check("s_acks", {30'd0, iack, dack}, 32'd0);
        tick();
        tick();
        sample();
        check("s_mreq",   {31'd0, mreq}, 32'd0);
        check("s_acks2",  {30'd0, iack, dack}, 32'd0);
        check("s_irdata", irdata, 32'h1111_2222);
        check("s_drdata", drdata, 32'h0BAD_F00D);
        mready = 1'b0;

        // ---- reset during a data read with mready in the same cycle ----
        dreq = 1'b1; dwe = 1'b0; daddr = 32'h0000_0300;
        tick();
        rst = 1'b1; mready = 1'b1; mrdata = 32'hCAFE_F00D;
        sample();
        check("r_dack", {31'd0, dack}, 32'd0);
        tick();
        rst = 1'b0; dreq = 1'b0; mready = 1'b0;
        sample();
        check("r_mreq",   {31'd0, mreq}, 32'd0);
        check("r_drdata", drdata, 32'd0);
        check("r_irdata", irdata, 32'd0);
        check("r_maddr",  maddr, 32'd0);

        // ---- arbitration order with both requests held from reset ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ireq = 1'b1; iaddr = 32'h0000_0040;
        dreq = 1'b1; daddr = 32'h0000_0300; dwe = 1'b0;
        mready = 1'b1; mrdata = 32'h0000_1000;
        sample();
        check("a_idle_acks", {30'd0, iack, dack}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            sample();
            exp_a = exp_d[k] ? 32'h300 : 32'h40;
            check($sformatf("a%0d_dack", k), {31'd0, dack}, {31'd0, exp_d[k]});
            check($sformatf("a%0d_iack", k), {31'd0, iack}, {31'd0, !exp_d[k]});
            check($sformatf("a%0d_maddr", k), maddr, exp_a);
            tick();
            sample();
            check($sformatf("a%0d_bubble", k), {31'd0, mreq}, 32'd0);
        end
        ireq = 1'b0; dreq = 1'b0; mready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
